mcp_ubus_master: RTL
====================

Name: mcp_ubus_master

Overview:
- Control-chip end of the 22-line active-low microinstruction bus; the MicROM is the responder.
- Generates the four non-overlapping clock phases C1..C4 from one system clock.
- Drives the 11-bit microaddress onto the bus during C2 and optionally pulls line 16 low during C3 to inhibit the ROM.
- Captures the returned microinstruction at the end of C1 and hands it to the core with a valid/ready request handshake.

Parameters:
- PHASE_CLKS, 2, system clocks per phase (legal 1..16); one microcycle = 4*PHASE_CLKS clocks.
- AW, 11, microaddress width (bus lines [AW-1:0]).
- DW, 22, microinstruction bus width.

Ports:
- pin_clk  in  1  system clock, all logic on rising edge.
- pin_rst_n  in  1  asynchronous active-low reset.
- pin_c1  out  1  phase 1: ROM drives bus, master captures.
- pin_c2  out  1  phase 2: master drives address.
- pin_c3  out  1  phase 3: ROM reads; master may pull line 16 low.
- pin_c4  out  1  phase 4: ROM precharges bus.
- pin_m_in  in  DW  sampled bus level (active-low, precharged high).
- pin_m_dl  out  DW  per-line drive-low enable (open-drain; 1 = pull line low).
- req_valid  in  1  core offers next microaddress.
- req_ready  out  1  master accepts request this clock.
- req_addr  in  AW  microaddress, true polarity.
- req_inh  in  1  inhibit ROM output for this microcycle.
- mi_valid  out  1  one-clock pulse: mi_data/mi_addr valid.
- mi_data  out  DW  captured microinstruction, true polarity (~pin_m_in).
- mi_addr  out  AW  address that produced mi_data.
- busy  out  1  microcycle in progress.

Behaviour:
- Reset (async, pin_rst_n low): all phases 0, pin_m_dl 0, mi_valid 0, mi_data 0, mi_addr 0, busy 0, state IDLE. Outputs release immediately, including mid-microcycle; the in-flight request is discarded and no mi_valid is produced.
- States: IDLE -> C2 -> C3 -> C4 -> C1 -> (C2 | IDLE). Each non-IDLE state lasts exactly PHASE_CLKS clocks, timed by a phase counter that counts 0..PHASE_CLKS-1.
- pin_cN is 1 exactly while in state CN (registered, glitch-free). At most one phase is high; all are 0 in IDLE.
- req_ready = 1 in IDLE, and on the last clock of C1. Otherwise 0.
- Acceptance is on an edge where req_valid & req_ready. It latches req_addr and req_inh and moves to C2.
- When not accepting on the last C1 clock, the master goes to IDLE.
- Drive rules:
  - C2: pin_m_dl[AW-1:0] = latched addr. Lines with a 1 address bit are pulled low, so the ROM sees ~bus = addr.
  - C3: pin_m_dl[16] = latched inh.
  - All other lines, and all lines in C1, C4 and IDLE: 0. The master never drives line 15 or lines [21:17].
- Capture: on the edge ending the last clock of C1, mi_data <= ~pin_m_in and mi_addr <= latched addr. mi_valid is 1 for the following clock only.
- With inhibit, the ROM stays off, the bus stays precharged and mi_data = 0 (unless an external source pulls lines).
- Latency: accept on edge 0 -> mi_valid high in the clock after edge 4*PHASE_CLKS.
- Back-to-back throughput: one microinstruction per 4*PHASE_CLKS clocks, with no IDLE gap.
- busy = 1 in every state except IDLE.
- mi_data/mi_addr hold their last value until the next capture.
- req_addr/req_inh changes after acceptance have no effect on the current microcycle.

Decomposition:
- Shared package mcp_pkg: state encoding (IDLE, C2, C3, C4, C1), bus line indices (MB_INH = 16, MB_PRE15 = 15), and AW/DW defaults.
- Sub-module mcp_phase_gen: phase counter and state register. Outputs pin_c1..c4, last_clk, and state. Inputs: start and continue.
- Top module contains the request latch, drive-low mux and capture register.

Test Plan:
- Reset then idle, P=2: all outputs 0, req_ready = 1, no phase toggles over 50 clocks.
- Single fetch, addr 11'h2A5, inh = 0; responder model returns 22'h12_3456. Required:
  - pin_m_dl[10:0] = 11'h2A5 during C2 only.
  - pin_m_dl[16] never set.
  - mi_valid pulses once, 9 clocks after acceptance, with mi_data = 22'h12_3456 and mi_addr = 11'h2A5.
- Inhibit cycle, addr 11'h7FF, inh = 1: pin_m_dl[16] = 1 for exactly C3; ROM model stays off; mi_data = 0.
- Back-to-back, req_valid held with addresses 0, 1, 2, P = 1: mi_valid every 4 clocks, mi_addr 0, 1, 2, no IDLE between.
- Async reset asserted mid-C3: pin_m_dl = 0 and phases = 0 without waiting for a clock edge; no mi_valid afterwards. After release, a new fetch completes normally.
- P=16 sweep: each phase is 16 clocks; req_ready is high only on the last C1 clock; stable req_valid and req_addr changes during C2..C4 are ignored.

Source files
------------

// File: rtl/mcp_pkg.sv
// Shared definitions for the microinstruction bus master: state codes, bus line indices, default widths.
// No logic of its own; latency and backpressure are properties of the modules that import it.
package mcp_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_C2   = 3'd1;
    localparam logic [2:0] ST_C3   = 3'd2;
    localparam logic [2:0] ST_C4   = 3'd3;
    localparam logic [2:0] ST_C1   = 3'd4;

    localparam int MB_INH   = 16;
    localparam int MB_PRE15 = 15;

    localparam int AW_DEF = 11;
    localparam int DW_DEF = 22;

    // Phase counter width; covers PHASE_CLKS up to 16.
    localparam int PCW = 4;

    // Returns {c4, c3, c2, c1} for a state code.
    function automatic logic [3:0] phase_onehot(input logic [2:0] s);
        case (s)
            ST_C1:   return 4'b0001;
            ST_C2:   return 4'b0010;
            ST_C3:   return 4'b0100;
            ST_C4:   return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mcp_phase_gen.sv
// Microcycle sequencer: IDLE -> C2 -> C3 -> C4 -> C1, each phase PHASE_CLKS clocks, phase pins registered.
// Latency: start seen on an edge enters C2 on that edge; backpressure: start/cont are only honoured in IDLE / last C1 clock.
module mcp_phase_gen
    import mcp_pkg::*;
#(
    parameter int PHASE_CLKS = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       cont_i,
    output logic       c1_o,
    output logic       c2_o,
    output logic       c3_o,
    output logic       c4_o,
    output logic       last_clk_o,
    output logic [2:0] state_o,
    output logic [2:0] state_nxt_o
);

    logic [PCW-1:0] cnt_q, cnt_d;
    logic [2:0]     state_q, state_d;
    logic [3:0]     ph_q, ph_d;
    logic           last_clk;

    assign last_clk = (state_q != ST_IDLE) && (cnt_q == PCW'(PHASE_CLKS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            if (start_i) begin
                state_d = ST_C2;
            end
        end else if (last_clk) begin
            cnt_d = '0;
            case (state_q)
                ST_C2:   state_d = ST_C3;
                ST_C3:   state_d = ST_C4;
                ST_C4:   state_d = ST_C1;
                ST_C1:   state_d = cont_i ? ST_C2 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + PCW'(1);
        end
        // Phase pins come from flops fed by the next state so they never glitch.
        ph_d = phase_onehot(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
        end
    end

    assign {c4_o, c3_o, c2_o, c1_o} = ph_q;
    assign last_clk_o  = last_clk;
    assign state_o     = state_q;
    assign state_nxt_o = state_d;

endmodule

// File: rtl/mcp_ubus_master.sv
// Control-chip master of the active-low microinstruction bus: drives address in C2, inhibit in C3, captures at end of C1.
// Latency 4*PHASE_CLKS clocks from accept to mi_valid; req_ready only in IDLE or on the last C1 clock, mi_valid cannot be stalled.
module mcp_ubus_master
    import mcp_pkg::*;
#(
    parameter int PHASE_CLKS = 2,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF
) (
    input  logic          pin_clk,
    input  logic          pin_rst_n,
    output logic          pin_c1,
    output logic          pin_c2,
    output logic          pin_c3,
    output logic          pin_c4,
    input  logic [DW-1:0] pin_m_in,
    output logic [DW-1:0] pin_m_dl,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    input  logic          req_inh,
    output logic          mi_valid,
    output logic [DW-1:0] mi_data,
    output logic [AW-1:0] mi_addr,
    output logic          busy
);

    logic [2:0]    state, state_nxt;
    logic          last_clk, in_idle, c1_last, accept;
    logic [AW-1:0] addr_q, addr_d;
    logic          inh_q, inh_d;
    logic [DW-1:0] dl_q, dl_d;
    logic          mi_vld_q;
    logic [DW-1:0] mi_data_q;
    logic [AW-1:0] mi_addr_q;

    assign in_idle   = (state == ST_IDLE);
    assign c1_last   = (state == ST_C1) && last_clk;
    assign req_ready = in_idle || c1_last;
    assign accept    = req_valid && req_ready;

    mcp_phase_gen #(
        .PHASE_CLKS(PHASE_CLKS)
    ) u_phase_gen (
        .clk_i      (pin_clk),
        .rst_ni     (pin_rst_n),
        .start_i    (accept && in_idle),
        .cont_i     (accept && c1_last),
        .c1_o       (pin_c1),
        .c2_o       (pin_c2),
        .c3_o       (pin_c3),
        .c4_o       (pin_c4),
        .last_clk_o (last_clk),
        .state_o    (state),
        .state_nxt_o(state_nxt)
    );

    assign addr_d = accept ? req_addr : addr_q;
    assign inh_d  = accept ? req_inh  : inh_q;

    // Drive enables are registered against the next state so they switch on the same edge as the phase pins.
    always_comb begin
        dl_d = '0;
        if (state_nxt == ST_C2) begin
            dl_d[AW-1:0] = addr_d;
        end
        if (state_nxt == ST_C3) begin
            dl_d[MB_INH] = inh_d;
        end
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            addr_q    <= '0;
            inh_q     <= 1'b0;
            dl_q      <= '0;
            mi_vld_q  <= 1'b0;
            mi_data_q <= '0;
            mi_addr_q <= '0;
        end else begin
            addr_q   <= addr_d;
            inh_q    <= inh_d;
            dl_q     <= dl_d;
            mi_vld_q <= c1_last;
            // addr_q still holds this microcycle's address even when a new request lands on the same edge.
            if (c1_last) begin
                mi_data_q <= ~pin_m_in;
                mi_addr_q <= addr_q;
            end
        end
    end

    assign pin_m_dl = dl_q;
    assign mi_valid = mi_vld_q;
    assign mi_data  = mi_data_q;
    assign mi_addr  = mi_addr_q;
    assign busy     = !in_idle;

endmodule
